// File: rtl/uart_rx_sequencer_pkg.sv
// Shared types and constants for the UART receive sequencer.
// Optional parity support is controlled by UART_RX_PARITY_EN (see uart_rx_sequencer.sv).
package uart_rx_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   localparam int OVERSAMPLE = 8;

   // Capture points sit mid-bit; the vote is resolved on the last sub-sample.
   localparam logic [2:0] SAMPLE_A = 3'd3;
   localparam logic [2:0] SAMPLE_B = 3'd4;
   localparam logic [2:0] SAMPLE_C = 3'd5;
   localparam logic [2:0] SC_LAST  = 3'd7;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sequencer_rx_bit_sampler.sv
// Line synchronizer plus three-point capture and majority vote for one bit period.
module rx_bit_sampler (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_tick,
   input  logic       rxd,
   input  logic [2:0] sc,
   output logic       rxd_sync,
   output logic       bit_vote
);
   import uart_rx_sequencer_pkg::*;

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic cap_a_q, cap_a_d;
   logic cap_b_q, cap_b_d;
   logic cap_c_q, cap_c_d;

   always_comb begin
      sync1_d = rxd;
      sync2_d = sync1_q;
      cap_a_d = cap_a_q;
      cap_b_d = cap_b_q;
      cap_c_d = cap_c_q;
      if (sample_tick) begin
         if (sc == SAMPLE_A) cap_a_d = sync2_q;
         if (sc == SAMPLE_B) cap_b_d = sync2_q;
         if (sc == SAMPLE_C) cap_c_d = sync2_q;
      end
   end

   // Everything resets to the idle-line level so no spurious start is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cap_a_q <= 1'b1;
         cap_b_q <= 1'b1;
         cap_c_q <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cap_a_q <= cap_a_d;
         cap_b_q <= cap_b_d;
         cap_c_q <= cap_c_d;
      end
   end

   assign rxd_sync = sync2_q;
   assign bit_vote = majority3(cap_a_q, cap_b_q, cap_c_q);

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: frame FSM, sub-sample/bit counters, shift register, valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | line idle, waiting for synced rxd low on a tick
// ST_START  | validating the start bit (false start -> ST_IDLE)
// ST_DATA   | collecting DATA_BITS data bits, LSB first
// ST_PARITY | checking even parity (UART_RX_PARITY_EN only)
// ST_STOP   | checking stop bit, delivering or discarding the byte
module uart_rx_sequencer #(
   parameter int OVERSAMPLE = uart_rx_sequencer_pkg::OVERSAMPLE,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample_tick,
   input  logic                 rxd,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 parity_err
);
   import uart_rx_sequencer_pkg::*;

   localparam int                IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [2:0]        SC_END   = 3'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);

   rx_state_e            state_q, state_d;
   logic [2:0]           sc_q, sc_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_err_q, overrun_err_d;
   logic                 deliver;
   logic                 line_sync;
   logic                 bit_vote;
`ifdef UART_RX_PARITY_EN
   logic                 discard_q, discard_d;
   logic                 parity_err_q, parity_err_d;
`endif

   rx_bit_sampler u_sampler (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_tick (sample_tick),
      .rxd         (rxd),
      .sc          (sc_q),
      .rxd_sync    (line_sync),
      .bit_vote    (bit_vote)
   );

   always_comb begin
      state_d       = state_q;
      sc_d          = sc_q;
      idx_d         = idx_q;
      shift_d       = shift_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q & ~rx_ready;
      frame_err_d   = 1'b0;
      overrun_err_d = 1'b0;
      deliver       = 1'b0;
`ifdef UART_RX_PARITY_EN
      discard_d     = discard_q;
      parity_err_d  = 1'b0;
`endif
      if (sample_tick) begin
         sc_d = (sc_q == SC_END) ? 3'd0 : sc_q + 3'd1;
         unique case (state_q)
            ST_IDLE: begin
               sc_d = 3'd0;
               // The detecting tick is sub-sample 0 of the start bit.
               if (!line_sync) begin
                  state_d = ST_START;
                  sc_d    = 3'd1;
               end
            end
            ST_START: begin
               if (sc_q == SC_END) begin
                  if (bit_vote) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DATA;
                     idx_d   = '0;
                  end
               end
            end
            ST_DATA: begin
               if (sc_q == SC_END) begin
                  shift_d[idx_q] = bit_vote;
                  if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (sc_q == SC_END) begin
                  if (^{shift_q, bit_vote}) discard_d = 1'b1;
                  state_d = ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (sc_q == SC_END) begin
                  state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                  // Parity error is reported here so it lines up with frame_err.
                  parity_err_d = discard_q;
                  discard_d    = 1'b0;
                  if (!bit_vote)       frame_err_d = 1'b1;
                  else if (!discard_q) deliver     = 1'b1;
`else
                  if (!bit_vote) frame_err_d = 1'b1;
                  else           deliver     = 1'b1;
`endif
               end
            end
            default: begin
               state_d = ST_IDLE;
               sc_d    = 3'd0;
            end
         endcase
      end

      // A byte accepted downstream this cycle frees the slot for the new one.
      if (deliver) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         sc_q          <= 3'd0;
         idx_q         <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sc_q          <= sc_d;
         idx_q         <= idx_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         discard_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         discard_q    <= discard_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = (state_q != ST_IDLE);
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_err_q;

endmodule
